// File: rtl/myfunc_pkg.sv
// Shared types and constants for the myfunc stimulus/capture sweeper.
// Imported by the sweeper top and its dwell timer.
package myfunc_pkg;

  localparam int CODE_W    = 4;
  localparam int NUM_CODES = 16;
  localparam int GAP_AFTER = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_DONE
  } sweep_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Serves both the per-code dwell and the mid-sweep idle gap.
module sweep_dwell_timer
  import myfunc_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/myfunc_sweeper.sv
// Walks myfunc through all 16 input codes, captures its truth table
// and compares it against a golden value.
module myfunc_sweeper
  import myfunc_pkg::*;
#(
  parameter int          DWELL    = 4,
  parameter int          GAP      = 2,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [CODE_W-1:0] abcd,
  input  logic              f_in,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tt,
  output logic              mismatch,
  output logic [CODE_W-1:0] first_bad
);

  localparam int MAXI  = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W = cnt_width(MAXI);
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [CNT_W-1:0]  DW_LD     = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]  GP_LD     = CNT_W'(GAP_M1);
  localparam logic [CODE_W-1:0] CODE_GAP  = CODE_W'(GAP_AFTER);
  localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(NUM_CODES - 1);

  sweep_state_e      state_q, state_d;
  logic [CODE_W-1:0] abcd_q, abcd_d;
  logic [15:0]       tt_q, tt_d;
  logic              mis_q, mis_d;
  logic [CODE_W-1:0] fb_q, fb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ld;
  logic [CNT_W-1:0]  ld_val;
  logic              tc;

  sweep_dwell_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ld),
    .load_val(ld_val),
    .tc      (tc)
  );

  always_comb begin
    state_d = state_q;
    abcd_d  = abcd_q;
    tt_d    = tt_q;
    mis_d   = mis_q;
    fb_d    = fb_q;
    ld      = 1'b0;
    ld_val  = DW_LD;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          abcd_d  = '0;
          ld      = 1'b1;
          tt_d    = '0;
          mis_d   = 1'b0;
          fb_d    = '0;
        end
      end
      ST_DRIVE: begin
        if (tc) begin
          tt_d[abcd_q] = f_in;
          // Only the lowest failing code is latched.
          if (f_in != EXPECTED[abcd_q] && !mis_q) begin
            mis_d = 1'b1;
            fb_d  = abcd_q;
          end
          if (abcd_q == CODE_GAP && GAP > 0) begin
            state_d = ST_GAP;
            ld      = 1'b1;
            ld_val  = GP_LD;
          end else if (abcd_q == CODE_LAST) begin
            state_d = ST_DONE;
          end else begin
            abcd_d = abcd_q + 1'b1;
            ld     = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tc) begin
          state_d = ST_DRIVE;
          abcd_d  = CODE_GAP + 1'b1;
          ld      = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        abcd_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      abcd_q  <= '0;
      tt_q    <= '0;
      mis_q   <= 1'b0;
      fb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abcd_q  <= abcd_d;
      tt_q    <= tt_d;
      mis_q   <= mis_d;
      fb_q    <= fb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign abcd      = abcd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tt        = tt_q;
  assign mismatch  = mis_q;
  assign first_bad = fb_q;

endmodule

// File: tb/tb_myfunc_sweeper.sv
// Randomized bench: four sweeper builds driven by a myfunc model
// with injectable faults, checked against a truth-table model.
module tb_myfunc_sweeper;

  localparam int NI = 4;

  function automatic int dw(input int g);
    return (g == 3) ? 1 : 4;
  endfunction

  function automatic int gp(input int g);
    return (g <= 1) ? 2 : 0;
  endfunction

  function automatic logic [15:0] exv(input int g);
    return (g == 1) ? 16'hF440 : 16'hF444;
  endfunction

  function automatic logic myf(input logic [3:0] x);
    return (x[3] & x[2]) | (x[1] & ~x[0]);
  endfunction

  logic        clk;
  logic        rst_n;
  logic        start     [NI];
  logic [3:0]  abcd      [NI];
  logic        f_in      [NI];
  logic        busy      [NI];
  logic        done      [NI];
  logic [15:0] tt        [NI];
  logic        mismatch  [NI];
  logic [3:0]  first_bad [NI];
  logic [15:0] flip      [NI];

  int n_chk;
  int n_fail;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    myfunc_sweeper #(
      .DWELL   (dw(g)),
      .GAP     (gp(g)),
      .EXPECTED(exv(g))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .abcd     (abcd[g]),
      .f_in     (f_in[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .tt       (tt[g]),
      .mismatch (mismatch[g]),
      .first_bad(first_bad[g])
    );
    assign f_in[g] = myf(abcd[g]) ^ flip[g][abcd[g]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_sweep(input int g, input logic [15:0] fl,
                           input bit spur);
    int d;
    int gl;
    int nb;
    int prev;
    int fb;
    bit seq_ok;
    int hold[16];
    logic [15:0] e_tt;
    logic [15:0] diff;
    d  = dw(g);
    gl = gp(g);
    flip[g] = fl;
    for (int i = 0; i < 16; i++) e_tt[i] = myf(4'(i)) ^ fl[i];
    diff = e_tt ^ exv(g);
    fb = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) fb = i;
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    chk($sformatf("g%0d busy_rise", g), 32'(busy[g]), 1);
    chk($sformatf("g%0d tt_clear", g), 32'(tt[g]), 0);
    chk($sformatf("g%0d abcd_first", g), 32'(abcd[g]), 0);
    foreach (hold[i]) hold[i] = 0;
    nb = 0;
    prev = 0;
    seq_ok = 1'b1;
    while (busy[g] && nb < 300) begin
      if (int'(abcd[g]) != prev && int'(abcd[g]) != prev + 1) seq_ok = 1'b0;
      hold[abcd[g]]++;
      prev = int'(abcd[g]);
      nb++;
      start[g] = spur && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    chk($sformatf("g%0d busy_len", g), 32'(nb), 32'(16 * d + gl));
    chk($sformatf("g%0d seq", g), 32'(seq_ok), 1);
    for (int i = 0; i < 16; i++)
      chk($sformatf("g%0d hold%0d", g, i), 32'(hold[i]),
          32'((i == 7) ? d + gl : d));
    chk($sformatf("g%0d done", g), 32'(done[g]), 1);
    chk($sformatf("g%0d tt", g), 32'(tt[g]), 32'(e_tt));
    chk($sformatf("g%0d mismatch", g), 32'(mismatch[g]),
        32'(diff != 16'h0));
    chk($sformatf("g%0d first_bad", g), 32'(first_bad[g]), 32'(fb));
    start[g] = spur;
    @(negedge clk);
    start[g] = 1'b0;
    chk($sformatf("g%0d done_fall", g), 32'(done[g]), 0);
    chk($sformatf("g%0d tt_hold", g), 32'(tt[g]), 32'(e_tt));
    @(negedge clk);
    chk($sformatf("g%0d idle", g), 32'(busy[g]), 0);
    flip[g] = 16'h0;
  endtask

  task automatic reset_test();
    int n;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (abcd[0] != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach5", 32'(abcd[0]), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abcd", 32'(abcd[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_tt", 32'(tt[0]), 0);
    chk("rst_mismatch", 32'(mismatch[0]), 0);
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done[0]) n++;
    end
    chk("rst_no_done", 32'(n), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stay_idle", 32'(busy[0]), 0);
  endtask

  initial begin
    logic [15:0] fl;
    int g;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      flip[i]  = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("g%0d r_abcd", i), 32'(abcd[i]), 0);
      chk($sformatf("g%0d r_busy", i), 32'(busy[i]), 0);
      chk($sformatf("g%0d r_done", i), 32'(done[i]), 0);
      chk($sformatf("g%0d r_tt", i), 32'(tt[i]), 0);
      chk($sformatf("g%0d r_mis", i), 32'(mismatch[i]), 0);
      chk($sformatf("g%0d r_fb", i), 32'(first_bad[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, 16'h0000, 1'b0);
    run_sweep(1, 16'h0000, 1'b0);
    run_sweep(1, 16'h0040, 1'b0);
    run_sweep(0, 16'h0000, 1'b1);
    run_sweep(0, 16'h0800, 1'b1);
    run_sweep(2, 16'h0000, 1'b1);
    run_sweep(3, 16'h0000, 1'b0);
    reset_test();
    run_sweep(0, 16'h0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      g  = int'($urandom_range(0, NI - 1));
      fl = 16'($urandom & $urandom & $urandom);
      run_sweep(g, fl, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
